// File: rtl/cmp_arbiter.sv
// cmp_arbiter: round-robin arbiter in front of a single unsigned comparator.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid[NREQ]       per-requester request
//   req_a/req_b           packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ready[NREQ]       one-hot accept strobe (combinational, IDLE only)
//   res_valid/res_ready   result handshake
//   res_id                owner of the held result
//   res_lt/res_eq/res_gt  unsigned compare flags
//   busy                  high whenever not IDLE
//   done_cnt              completed-transaction counter (wraps)
module cmp_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [1:0]            res_id,
    output logic                  res_lt,
    output logic                  res_eq,
    output logic                  res_gt,
    output logic                  busy,
    output logic [15:0]           done_cnt
);

    localparam int unsigned IDW = 2;
    localparam int unsigned CNTW = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMP  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [IDW-1:0]   ptr_q,       ptr_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [IDW-1:0]   id_q,        id_d;
    logic [IDW-1:0]   res_id_q,    res_id_d;
    logic             res_lt_q,    res_lt_d;
    logic             res_eq_q,    res_eq_d;
    logic             res_gt_q,    res_gt_d;
    logic             res_valid_q, res_valid_d;
    logic             busy_q,      busy_d;
    logic [CNTW-1:0]  done_cnt_q,  done_cnt_d;

    logic             grant_found;
    logic [IDW-1:0]   grant_id;
    logic [IDW-1:0]   cand;

    // Round-robin search: first valid requester at or after ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IDW'((32'(ptr_q) + i) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_id    = cand;
            end
        end
    end

    // Accept strobe only in IDLE; forced low while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == ST_IDLE) && grant_found) begin
            req_ready = NREQ'(1'b1) << grant_id;
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        a_d        = a_q;
        b_d        = b_q;
        id_d       = id_q;
        res_id_d   = res_id_q;
        res_lt_d   = res_lt_q;
        res_eq_d   = res_eq_q;
        res_gt_d   = res_gt_q;
        done_cnt_d = done_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    a_d     = req_a[32'(grant_id) * WIDTH +: WIDTH];
                    b_d     = req_b[32'(grant_id) * WIDTH +: WIDTH];
                    id_d    = grant_id;
                    ptr_d   = IDW'(grant_id + IDW'(1));
                    state_d = ST_CMP;
                end
            end
            ST_CMP: begin
                res_id_d = id_q;
                res_lt_d = (a_q <  b_q);
                res_eq_d = (a_q == b_q);
                res_gt_d = (a_q >  b_q);
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (res_ready) begin
                    done_cnt_d = CNTW'(done_cnt_q + CNTW'(1));
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        res_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            res_id_q    <= '0;
            res_lt_q    <= 1'b0;
            res_eq_q    <= 1'b0;
            res_gt_q    <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            id_q        <= id_d;
            res_id_q    <= res_id_d;
            res_lt_q    <= res_lt_d;
            res_eq_q    <= res_eq_d;
            res_gt_q    <= res_gt_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_lt    = res_lt_q;
    assign res_eq    = res_eq_q;
    assign res_gt    = res_gt_q;
    assign busy      = busy_q;
    assign done_cnt  = done_cnt_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter with a result scoreboard.
module tb_cmp_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 4;

    typedef struct packed {
        logic [1:0] id;
        logic       lt;
        logic       eq;
        logic       gt;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  res_valid;
    logic                  res_ready;
    logic [1:0]            res_id;
    logic                  res_lt, res_eq, res_gt;
    logic                  busy;
    logic [15:0]           done_cnt;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_err    = 0;
    logic [15:0] exp_cnt  = 16'd0;

    cmp_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_lt(res_lt), .res_eq(res_eq), .res_gt(res_gt),
        .busy(busy), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic [1:0] id, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.id = id;
        e.lt = (a < b);
        e.eq = (a == b);
        e.gt = (a > b);
        return e;
    endfunction

    // Scoreboard: compare every accepted result with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'(res_id), 32'hDEAD);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_result", 32'({res_id, res_lt, res_eq, res_gt}), 32'(e));
            end
        end
    end

    // One transaction from a single requester, checking grant, latency and count.
    task automatic txn(input int id, input logic [7:0] a, input logic [7:0] b);
        bit found;
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        sb.push_back(mk_exp(2'(id), a, b));
        req_valid = NREQ'(1) << id;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                found = 1'b1;
                break;
            end
        end
        chk("grant_seen", 32'(found), 32'd1);
        chk("grant_onehot", 32'(req_ready), 32'(NREQ'(1) << id));
        @(posedge clk); #1;
        req_valid = '0;
        req_a = $urandom;
        req_b = $urandom;
        @(negedge clk);
        chk("cmp_res_valid", 32'(res_valid), 32'd0);
        chk("cmp_busy", 32'(busy), 32'd1);
        res_ready = 1'b1;
        @(negedge clk);
        chk("lat_res_valid", 32'(res_valid), 32'd1);
        @(posedge clk); #1;
        res_ready = 1'b0;
        exp_cnt = 16'(exp_cnt + 16'd1);
        chk("done_cnt", 32'(done_cnt), 32'(exp_cnt));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_res_id"},    32'(res_id),    32'd0);
        chk({tag, "_flags"},     32'({res_lt, res_eq, res_gt}), 32'd0);
        chk({tag, "_busy"},      32'(busy),      32'd0);
        chk({tag, "_done_cnt"},  32'(done_cnt),  32'd0);
    endtask

    initial begin
        int   gcount;
        int   last_cyc;
        int   cyc;
        int   order[5];
        exp_t hold_e;
        bit   found;

        // Reset with requests already pending: no accept strobe allowed.
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b0;
        #3;
        chk_reset_vals("por");
        #19;
        req_valid = '0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 32'd0);

        // Single requester 0: A<B.
        txn(0, 8'h34, 8'h50);

        // Requester 2 across compare outcomes and extremes.
        txn(2, 8'hB6, 8'h58);
        txn(2, 8'h7F, 8'h7F);
        txn(2, 8'h00, 8'hFF);
        txn(2, 8'hFF, 8'h00);

        // Reset in the middle of CMP discards the transaction.
        req_a[1*WIDTH +: WIDTH] = 8'h12;
        req_b[1*WIDTH +: WIDTH] = 8'h34;
        req_valid = 4'b0010;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                found = 1'b1;
                break;
            end
        end
        chk("rst_grant_seen", 32'(found), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        chk("rst_pre_busy", 32'(busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midcmp");
        exp_cnt = 16'd0;
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;

        // All four requesting with res_ready held: strict rotation, 3-cycle spacing.
        req_a = {8'h00, 8'h32, 8'h1E, 8'h0A};
        req_b = {8'h01, 8'h28, 8'h1E, 8'h14};
        order = '{0, 1, 2, 3, 0};
        for (int g = 0; g < 5; g++) begin
            logic [7:0] a_v, b_v;
            logic [NREQ*WIDTH-1:0] ta, tb;
            ta  = req_a;
            tb  = req_b;
            a_v = ta[order[g]*WIDTH +: WIDTH];
            b_v = tb[order[g]*WIDTH +: WIDTH];
            sb.push_back(mk_exp(2'(order[g]), a_v, b_v));
        end
        @(posedge clk); #1;
        req_valid = 4'hF;
        res_ready = 1'b1;
        gcount    = 0;
        last_cyc  = 0;
        cyc       = 0;
        while (gcount < 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (req_ready != '0) begin
                chk("rr_grant", 32'(req_ready), 32'(NREQ'(1) << order[gcount]));
                if (gcount > 0) chk("rr_spacing", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                gcount++;
            end
        end
        chk("rr_grant_count", 32'(gcount), 32'd5);
        @(posedge clk); #1;
        req_valid = '0;
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        chk("rr_sb_drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
        res_ready = 1'b0;
        exp_cnt = 16'd5;
        chk("rr_done_cnt", 32'(done_cnt), 32'(exp_cnt));

        // Backpressure in RESP while inputs churn.
        req_a[3*WIDTH +: WIDTH] = 8'h11;
        req_b[3*WIDTH +: WIDTH] = 8'h22;
        hold_e = mk_exp(2'd3, 8'h11, 8'h22);
        sb.push_back(hold_e);
        req_valid = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (req_ready != '0) break;
        end
        chk("hold_grant", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        req_valid = 4'hF;
        @(posedge clk); #1;
        for (int k = 0; k < 10; k++) begin
            req_a = $urandom;
            req_b = $urandom;
            @(negedge clk);
            chk("hold_res_valid", 32'(res_valid), 32'd1);
            chk("hold_res", 32'({res_id, res_lt, res_eq, res_gt}), 32'(hold_e));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        req_valid = '0;
        exp_cnt = 16'(exp_cnt + 16'd1);
        chk("hold_done_cnt", 32'(done_cnt), 32'(exp_cnt));
        chk("hold_sb_drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
        chk("hold_after_valid", 32'(res_valid), 32'd0);

        // Counter wrap: preload near the top, then count through 0xFFFF.
        @(posedge clk); #1;
        force dut.done_cnt_q = 16'hFFFD;
        #1;
        release dut.done_cnt_q;
        exp_cnt = 16'hFFFD;
        @(posedge clk); #1;
        chk("wrap_preload", 32'(done_cnt), 32'hFFFD);
        txn(1, 8'h01, 8'h02);
        txn(1, 8'h03, 8'h03);
        txn(1, 8'h09, 8'h04);
        chk("wrap_zero", 32'(done_cnt), 32'h0000);

        repeat (3) @(posedge clk);
        chk("final_sb_drain", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
